// File: rtl/alu_pkg.sv
// Shared opcode, state and flag-index definitions for the sequential ALU.
package alu_pkg;

  localparam logic [4:0] ALU_AND = 5'b00000;
  localparam logic [4:0] ALU_OR  = 5'b00001;
  localparam logic [4:0] ALU_XOR = 5'b00010;
  localparam logic [4:0] ALU_NOT = 5'b00011;
  localparam logic [4:0] ALU_ADD = 5'b00100;
  localparam logic [4:0] ALU_SUB = 5'b00101;
  localparam logic [4:0] ALU_SHL = 5'b00110;
  localparam logic [4:0] ALU_SHR = 5'b00111;
  localparam logic [4:0] ALU_SAR = 5'b01000;
  localparam logic [4:0] ALU_MUL = 5'b01001;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_e;

  localparam int unsigned FLAG_C    = 0;
  localparam int unsigned FLAG_N    = 1;
  localparam int unsigned FLAG_V    = 2;
  localparam int unsigned FLAG_Z    = 3;
  localparam int unsigned NUM_FLAGS = 4;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add unsigned multiplier: one partial product per cycle, Width cycles total.
module alu_mul_iter #(
  parameter int unsigned Width = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [Width-1:0]   a_i,
  input  logic [Width-1:0]   b_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [2*Width-1:0] product_o
);

  localparam int unsigned CntW = $clog2(Width);
  localparam logic [CntW-1:0] LastCnt = CntW'(Width - 1);

  logic [Width-1:0]   mcand_q, mcand_d;
  logic [2*Width-1:0] acc_q, acc_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [Width:0]     partial;

  always_comb begin
    mcand_d = mcand_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    // Upper half accumulates; multiplier bits drain out of the lower half.
    partial = {1'b0, acc_q[2*Width-1:Width]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    if (start_i) begin
      mcand_d = a_i;
      acc_d   = {{Width{1'b0}}, b_i};
      cnt_d   = '0;
      busy_d  = 1'b1;
      done_d  = 1'b0;
    end else if (busy_q) begin
      acc_d = {partial, acc_q[Width-1:1]};
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LastCnt) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mcand_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign product_o = acc_q;

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle logic/arith/shift ops, iterative multiply, registered result and flags.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  localparam int unsigned SHW = $clog2(WIDTH)
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             InValid,
  output logic             InReady,
  input  logic [4:0]       Opcode,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] Result,
  output logic             Carry,
  output logic             Negative,
  output logic             Overflow,
  output logic             Zero,
  output logic             Illegal
);

  localparam int unsigned Msb = WIDTH - 1;

  state_e                 state_q, state_d;
  logic [WIDTH-1:0]       res_q, res_d;
  logic [NUM_FLAGS-1:0]   flags_q, flags_d;
  logic                   illegal_q, illegal_d;

  logic                   accept, take, is_mul, mul_start, mul_busy, mul_done;
  logic [2*WIDTH-1:0]     mul_product;
  logic [SHW-1:0]         sh_amt;
  logic [WIDTH:0]         add_ext, sub_ext, shl_ext, shr_ext;
  logic signed [WIDTH:0]  sar_ext;
  logic [WIDTH-1:0]       alu_res;
  logic                   alu_c, alu_v, alu_ill;

  alu_mul_iter #(.Width(WIDTH)) u_mul (
    .clk_i    (Clock),
    .rst_ni   (Reset_n),
    .start_i  (mul_start),
    .a_i      (OperandA),
    .b_i      (OperandB),
    .busy_o   (mul_busy),
    .done_o   (mul_done),
    .product_o(mul_product)
  );

  always_comb begin
    sh_amt  = OperandB[SHW-1:0];
    add_ext = {1'b0, OperandA} + {1'b0, OperandB};
    sub_ext = {1'b0, OperandA} + {1'b0, ~OperandB} + {{WIDTH{1'b0}}, 1'b1};
    // Shifts carry one guard bit so the last bit shifted out lands in bit 0 / bit WIDTH.
    shl_ext = {1'b0, OperandA} << sh_amt;
    shr_ext = {OperandA, 1'b0} >> sh_amt;
    sar_ext = $signed({OperandA, 1'b0}) >>> sh_amt;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_ill = 1'b0;
    case (Opcode)
      ALU_AND: alu_res = OperandA & OperandB;
      ALU_OR:  alu_res = OperandA | OperandB;
      ALU_XOR: alu_res = OperandA ^ OperandB;
      ALU_NOT: alu_res = ~OperandA;
      ALU_ADD: begin
        alu_res = add_ext[WIDTH-1:0];
        alu_c   = add_ext[WIDTH];
        alu_v   = (OperandA[Msb] == OperandB[Msb]) && (alu_res[Msb] != OperandA[Msb]);
      end
      ALU_SUB: begin
        alu_res = sub_ext[WIDTH-1:0];
        alu_c   = sub_ext[WIDTH];
        alu_v   = (OperandA[Msb] != OperandB[Msb]) && (alu_res[Msb] != OperandA[Msb]);
      end
      ALU_SHL: begin
        alu_res = shl_ext[WIDTH-1:0];
        alu_c   = shl_ext[WIDTH];
      end
      ALU_SHR: begin
        alu_res = shr_ext[WIDTH:1];
        alu_c   = shr_ext[0];
      end
      ALU_SAR: begin
        alu_res = sar_ext[WIDTH:1];
        alu_c   = sar_ext[0];
      end
      ALU_MUL: ;
      default: alu_ill = 1'b1;
    endcase
  end

  always_comb begin
    InReady   = Reset_n && ((state_q == S_IDLE) || ((state_q == S_DONE) && OutReady));
    accept    = InValid && InReady;
    take      = (state_q == S_DONE) && OutReady;
    is_mul    = (Opcode == ALU_MUL);
    mul_start = accept && is_mul;
    state_d   = state_q;
    res_d     = res_q;
    flags_d   = flags_q;
    illegal_d = illegal_q;
    if (accept && !is_mul) begin
      res_d           = alu_res;
      flags_d[FLAG_C] = alu_c;
      flags_d[FLAG_V] = alu_v;
      flags_d[FLAG_N] = alu_res[Msb];
      flags_d[FLAG_Z] = ~|alu_res;
      illegal_d       = alu_ill;
      state_d         = S_DONE;
    end else if (mul_start) begin
      state_d = S_MUL;
    end else if ((state_q == S_MUL) && mul_done && !mul_busy) begin
      res_d           = mul_product[WIDTH-1:0];
      flags_d[FLAG_C] = 1'b0;
      flags_d[FLAG_V] = |mul_product[2*WIDTH-1:WIDTH];
      flags_d[FLAG_N] = mul_product[Msb];
      flags_d[FLAG_Z] = ~|mul_product[WIDTH-1:0];
      illegal_d       = 1'b0;
      state_d         = S_DONE;
    end else if (take) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_q   <= S_IDLE;
      res_q     <= '0;
      flags_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      res_q     <= res_d;
      flags_q   <= flags_d;
      illegal_q <= illegal_d;
    end
  end

  assign OutValid = (state_q == S_DONE);
  assign Result   = res_q;
  assign Carry    = flags_q[FLAG_C];
  assign Negative = flags_q[FLAG_N];
  assign Overflow = flags_q[FLAG_V];
  assign Zero     = flags_q[FLAG_Z];
  assign Illegal  = illegal_q;

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the team's 16-bit combinational logic ALU. Adds arithmetic, shifts and an iterative multiply, plus registered results with Carry/Negative/Overflow/Zero flags. Sits between the register-file read stage and write-back, with valid/ready on both sides so multi-cycle operations can stall the datapath.

## Interface
- WIDTH, 16: operand/result width in bits, ≥4, power of two.
- SHW, $clog2(WIDTH): shift-amount width (derived, not overridden).
- Clock  input  1  single clock, rising edge.
- Reset_n  input  1  synchronous, active-low reset.
- InValid  input  1  operation presented.
- InReady  output  1  block can accept an operation this cycle.
- Opcode  input  5  operation select.
- OperandA  input  WIDTH  first operand.
- OperandB  input  WIDTH  second operand / shift amount.
- OutValid  output  1  Result and flags valid.
- OutReady  input  1  consumer takes result this cycle.
- Result  output  WIDTH  registered result.
- Carry, Negative, Overflow, Zero  output  1 each  registered flags.
- Illegal  output  1  registered; opcode was unassigned.

## Operation
- Opcodes: 00000 AND, 00001 OR, 00010 XOR, 00011 NOT A, 00100 ADD, 00101 SUB (A−B), 00110 SHL, 00111 SHR (logical), 01000 SAR, 01001 MUL (unsigned, low WIDTH bits). All others illegal.
- Transfer in: InValid && InReady at a rising edge. Transfer out: OutValid && OutReady.
- States: IDLE, MUL, DONE.
  - IDLE: InReady=1. Non-MUL accepted → compute, register, go DONE. MUL accepted → load multiplier, go MUL.
  - MUL: InReady=0. One shift-add step per cycle, WIDTH steps, then register the result and go DONE.
  - DONE: OutValid=1; Result/flags held stable until taken. InReady = OutReady. Take with no new op → IDLE. Take plus new non-MUL op in the same cycle → stay DONE with the new result (back-to-back, no bubble). Take plus MUL → MUL.
- Flags: Negative = Result[WIDTH-1]; Zero = (Result==0) for all ops.
  - ADD: Carry = carry-out; Overflow = signed overflow.
  - SUB: computed as A+~B+1; Carry = carry-out (1 = no borrow); Overflow = signed overflow.
  - Shifts: amount = OperandB[SHW-1:0], upper bits ignored. Carry = last bit shifted out, 0 when amount is 0. Overflow=0.
  - MUL: Overflow = 1 if the upper WIDTH bits of the full product are nonzero; Carry=0.
  - Logic ops: Carry=Overflow=0.
- Illegal opcode: accepted like a single-cycle op. Result=0, Carry=Overflow=Negative=0, Zero=1, Illegal=1. Illegal=0 for legal ops.

## Timing
- Reset (Reset_n low at edge): state IDLE; Result=0; all flags 0; Illegal=0; OutValid=0; multiplier registers cleared. InReady=0 while Reset_n low, 1 the first cycle after release.
- Reset mid-MUL or in DONE: operation and pending result discarded, no OutValid.
- Single-cycle ops: OutValid rises the cycle after acceptance (latency 1). Throughput 1/cycle while OutReady=1.
- MUL: accepted at edge N, OutValid at edge N+WIDTH+1.
- OutValid never deasserts without a take (or reset). Result/flags must not change while OutValid=1 and OutReady=0.
- InValid while InReady=0 is ignored; the upstream stage holds its operands.

## Structure
- Package alu_pkg: opcode localparams (ALU_AND … ALU_MUL), state enum (S_IDLE, S_MUL, S_DONE), flag-bit index constants.
- Sub-module alu_mul_iter: shift-add multiplier (Start, Busy, Done, 2·WIDTH product). The top level holds the FSM, single-cycle datapath, flag logic and output register.

## Test plan
- WIDTH=16, ADD 0x7FFF+0x0001 → Result 0x8000, Overflow=1, Negative=1, Carry=0, Zero=0; OutValid exactly 1 cycle after accept.
- SUB 0x0000−0x0001 → 0xFFFF, Carry=0, Negative=1; SUB 0x0005−0x0005 → 0x0000, Carry=1, Zero=1.
- SAR 0x8001 by OperandB=0xFFF1 (amount 1) → 0xC000, Carry=1; SHL by 0 → unchanged, Carry=0.
- MUL 0x0100×0x0100 → Result 0x0000, Overflow=1, Zero=1, OutValid 17 cycles after accept, InReady=0 throughout; MUL 3×5 → 0x000F, Overflow=0.
- Back-to-back AND/OR/XOR with OutReady=1 → one result per cycle. OutReady held 0 for 5 cycles → Result stable, InReady=0; then take.
- Reset_n low during MUL cycle 8 → OutValid stays 0, InReady=1 after release. Opcode 11111 → Illegal=1, Result=0, Zero=1.
